// File: rtl/sram_access_target.sv
// rtl/sram_access_target.sv - 64-bit synchronous SRAM target for sram_access requests
// Memory array, fixed-latency response pipeline and post-reset memory-clear sequencer.
module sram_access_target #(
  parameter int ADDR_W         = 10,
  parameter int LATENCY        = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        sram_access_req__valid,
  input  logic [7:0]  sram_access_req__id,
  input  logic        sram_access_req__read_not_write,
  input  logic [7:0]  sram_access_req__byte_enable,
  input  logic [31:0] sram_access_req__address,
  input  logic [63:0] sram_access_req__write_data,
  output logic        sram_access_resp__ack,
  output logic        sram_access_resp__valid,
  output logic [7:0]  sram_access_resp__id,
  output logic [63:0] sram_access_resp__data,
  output logic        init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [63:0]         mem [DEPTH];

  logic [LATENCY-1:0]  pipe_valid_q, pipe_valid_d;
  logic [7:0]          pipe_id_q   [LATENCY];
  logic [7:0]          pipe_id_d   [LATENCY];
  logic [63:0]         pipe_data_q [LATENCY];
  logic [63:0]         pipe_data_d [LATENCY];

  logic                ready;
  logic                accept;
  logic                in_range;
  logic [ADDR_W-1:0]   word_addr;
  logic [63:0]         rd_word;
  logic [63:0]         merged_word;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [63:0]         mem_wdata;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // FSM: next state; the clear walks every word once, then READY is terminal
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (clk__enable && state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == '1) begin
        state_d = ST_READY;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    ready                 = (state_q == ST_READY);
    init_done             = ready;
    sram_access_resp__ack = sram_access_req__valid & ready;
  end

  always_comb begin
    accept    = sram_access_resp__ack & clk__enable;
    in_range  = (sram_access_req__address >> ADDR_W) == 32'd0;
    word_addr = sram_access_req__address[ADDR_W-1:0];
    rd_word   = mem[word_addr];
    for (int b = 0; b < 8; b++) begin
      merged_word[8*b +: 8] = sram_access_req__byte_enable[b] ?
                              sram_access_req__write_data[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  // Single write port shared by the clear sequencer and accepted writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = clk__enable;
      mem_waddr = clr_ptr_q;
    end else if (accept && !sram_access_req__read_not_write && in_range) begin
      mem_we    = 1'b1;
      mem_waddr = word_addr;
      mem_wdata = merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Response pipeline; writes and out-of-range reads carry zero data
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_id_d    = pipe_id_q;
    pipe_data_d  = pipe_data_q;
    if (clk__enable) begin
      pipe_valid_d[0] = accept;
      pipe_id_d[0]    = accept ? sram_access_req__id : 8'h00;
      pipe_data_d[0]  = (accept && sram_access_req__read_not_write && in_range) ? rd_word : 64'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_d[i] = pipe_valid_q[i-1];
        pipe_id_d[i]    = pipe_id_q[i-1];
        pipe_data_d[i]  = pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_id_q[i]   <= 8'h00;
        pipe_data_q[i] <= 64'h0;
      end
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_id_q    <= pipe_id_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  assign sram_access_resp__valid = pipe_valid_q[LATENCY-1];
  assign sram_access_resp__id    = pipe_id_q[LATENCY-1];
  assign sram_access_resp__data  = pipe_data_q[LATENCY-1];

endmodule

// File: tb/tb_sram_access_target.sv
// tb/tb_sram_access_target.sv - directed self-checking bench for sram_access_target
// Runs with ADDR_W=4 (16 words) and LATENCY=3.
module tb_sram_access_target;

  localparam int ADDR_W = 4;
  localparam int LAT    = 3;

  logic        clk = 1'b0;
  logic        clk__enable;
  logic        reset_n;
  logic        req_valid;
  logic [7:0]  req_id;
  logic        req_rnw;
  logic [7:0]  req_be;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        ack;
  logic        resp_valid;
  logic [7:0]  resp_id;
  logic [63:0] resp_data;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rq_rnw  [8];
  logic [7:0]  rq_id   [8];
  logic [31:0] rq_addr [8];
  logic [63:0] rq_data [8];
  logic [7:0]  rq_be   [8];
  logic [63:0] ex_d    [8];
  logic        obs_ack [16];
  logic        obs_v   [16];
  logic [7:0]  obs_id  [16];
  logic [63:0] obs_d   [16];

  sram_access_target #(
    .ADDR_W(ADDR_W),
    .LATENCY(LAT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk                             (clk),
    .clk__enable                     (clk__enable),
    .reset_n                         (reset_n),
    .sram_access_req__valid          (req_valid),
    .sram_access_req__id             (req_id),
    .sram_access_req__read_not_write (req_rnw),
    .sram_access_req__byte_enable    (req_be),
    .sram_access_req__address        (req_addr),
    .sram_access_req__write_data     (req_wdata),
    .sram_access_resp__ack           (ack),
    .sram_access_resp__valid         (resp_valid),
    .sram_access_resp__id            (resp_id),
    .sram_access_resp__data          (resp_data),
    .init_done                       (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic rnw, input logic [7:0] id,
                         input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    req_valid = v;
    req_rnw   = rnw;
    req_id    = id;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic set_vec(input int k, input logic rnw, input logic [7:0] id, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] be, input logic [63:0] exp_d);
    rq_rnw[k]  = rnw;
    rq_id[k]   = id;
    rq_addr[k] = a;
    rq_data[k] = d;
    rq_be[k]   = be;
    ex_d[k]    = exp_d;
  endtask

  // Issues n back-to-back requests and records outputs every cycle from the first request on.
  task automatic drive_seq(input int n);
    for (int c = 0; c < n + LAT + 1; c++) begin
      if (c < n) set_req(1'b1, rq_rnw[c], rq_id[c], rq_addr[c], rq_data[c], rq_be[c]);
      else       set_req(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 8'h00);
      #1;
      obs_ack[c] = ack;
      obs_v[c]   = resp_valid;
      obs_id[c]  = resp_id;
      obs_d[c]   = resp_data;
      tick;
    end
  endtask

  task automatic test_reset;
    clk__enable = 1'b1;
    reset_n     = 1'b0;
    set_req(1'b1, 1'b1, 8'h55, 32'h0, 64'h0, 8'h00);
    repeat (2) tick;
    n_tests++;
    if (resp_valid !== 1'b0 || resp_id !== 8'h00 || resp_data !== 64'h0 || init_done !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b id=%h data=%h init_done=%b ack=%b, required all 0",
               resp_valid, resp_id, resp_data, init_done, ack);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_tests++;
      if (ack !== 1'b0 || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_busy cycle %0d: ack=%b init_done=%b, required 0/0", c, ack, init_done);
      end
      tick;
    end
    n_tests++;
    if (ack !== 1'b1 || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_done cycle 16: ack=%b init_done=%b, required 1/1", ack, init_done);
    end
    tick;
    set_req(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 8'h00);
    repeat (LAT - 1) tick;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 8'h55 || resp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL first_read: valid=%b id=%h data=%h, required 1 55 0", resp_valid, resp_id, resp_data);
    end
    tick;
  endtask

  task automatic test_write_read;
    set_vec(0, 1'b0, 8'h11, 32'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0);
    set_vec(1, 1'b1, 8'h12, 32'd3, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
    drive_seq(2);
    for (int c = 0; c < 2 + LAT + 1; c++) begin
      n_tests++;
      if (obs_v[c] !== ((c >= LAT) && (c < 2 + LAT)) || (c < 2 && obs_ack[c] !== 1'b1)) begin
        n_fail++;
        $display("FAIL write_read cycle %0d: valid=%b ack=%b, required valid=%b", c, obs_v[c], obs_ack[c],
                 (c >= LAT) && (c < 2 + LAT));
      end
      if (c >= LAT && c < 2 + LAT) begin
        n_tests++;
        if (obs_id[c] !== rq_id[c-LAT] || obs_d[c] !== ex_d[c-LAT]) begin
          n_fail++;
          $display("FAIL write_read resp %0d: id=%h data=%h, required id=%h data=%h", c - LAT,
                   obs_id[c], obs_d[c], rq_id[c-LAT], ex_d[c-LAT]);
        end
      end
    end
  endtask

  task automatic test_partial_write;
    set_vec(0, 1'b0, 8'h13, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0);
    set_vec(1, 1'b1, 8'h14, 32'd3, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF);
    set_vec(2, 1'b0, 8'h15, 32'd3, 64'hDEAD_DEAD_DEAD_DEAD, 8'h00, 64'h0);
    set_vec(3, 1'b1, 8'h16, 32'd3, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF);
    drive_seq(4);
    for (int c = 0; c < 4 + LAT + 1; c++) begin
      n_tests++;
      if (obs_v[c] !== ((c >= LAT) && (c < 4 + LAT)) || (c < 4 && obs_ack[c] !== 1'b1)) begin
        n_fail++;
        $display("FAIL partial cycle %0d: valid=%b ack=%b, required valid=%b", c, obs_v[c], obs_ack[c],
                 (c >= LAT) && (c < 4 + LAT));
      end
      if (c >= LAT && c < 4 + LAT) begin
        n_tests++;
        if (obs_id[c] !== rq_id[c-LAT] || obs_d[c] !== ex_d[c-LAT]) begin
          n_fail++;
          $display("FAIL partial resp %0d: id=%h data=%h, required id=%h data=%h", c - LAT,
                   obs_id[c], obs_d[c], rq_id[c-LAT], ex_d[c-LAT]);
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    set_vec(0, 1'b0, 8'h31, 32'h0000_1003, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0);
    set_vec(1, 1'b1, 8'h32, 32'h0000_1003, 64'h0, 8'h00, 64'h0);
    set_vec(2, 1'b1, 8'h33, 32'd3, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF);
    set_vec(3, 1'b1, 8'h34, 32'h0000_1000, 64'h0, 8'h00, 64'h0);
    drive_seq(4);
    for (int c = 0; c < 4 + LAT + 1; c++) begin
      n_tests++;
      if (obs_v[c] !== ((c >= LAT) && (c < 4 + LAT)) || (c < 4 && obs_ack[c] !== 1'b1)) begin
        n_fail++;
        $display("FAIL oor cycle %0d: valid=%b ack=%b, required valid=%b", c, obs_v[c], obs_ack[c],
                 (c >= LAT) && (c < 4 + LAT));
      end
      if (c >= LAT && c < 4 + LAT) begin
        n_tests++;
        if (obs_id[c] !== rq_id[c-LAT] || obs_d[c] !== ex_d[c-LAT]) begin
          n_fail++;
          $display("FAIL oor resp %0d: id=%h data=%h, required id=%h data=%h", c - LAT,
                   obs_id[c], obs_d[c], rq_id[c-LAT], ex_d[c-LAT]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    set_vec(0, 1'b1, 8'h01, 32'd3, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF);
    set_vec(1, 1'b1, 8'h02, 32'd0, 64'h0, 8'h00, 64'h0);
    set_vec(2, 1'b1, 8'h03, 32'd3, 64'h0, 8'h00, 64'h0123_4567_FFFF_FFFF);
    set_vec(3, 1'b1, 8'h04, 32'd15, 64'h0, 8'h00, 64'h0);
    drive_seq(4);
    for (int c = 0; c < 4 + LAT + 1; c++) begin
      n_tests++;
      if (obs_v[c] !== ((c >= LAT) && (c < 4 + LAT)) || (c < 4 && obs_ack[c] !== 1'b1)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: valid=%b ack=%b, required valid=%b", c, obs_v[c], obs_ack[c],
                 (c >= LAT) && (c < 4 + LAT));
      end
      if (c >= LAT && c < 4 + LAT) begin
        n_tests++;
        if (obs_id[c] !== rq_id[c-LAT] || obs_d[c] !== ex_d[c-LAT]) begin
          n_fail++;
          $display("FAIL b2b resp %0d: id=%h data=%h, required id=%h data=%h", c - LAT,
                   obs_id[c], obs_d[c], rq_id[c-LAT], ex_d[c-LAT]);
        end
      end
    end
  endtask

  task automatic test_clk_enable;
    clk__enable = 1'b0;
    set_req(1'b1, 1'b1, 8'h21, 32'd3, 64'h0, 8'h00);
    #1;
    n_tests++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL en_low_ack: ack=%b, required 1", ack);
    end
    repeat (3) tick;
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_low_no_xfer: valid=%b, required 0", resp_valid);
    end
    clk__enable = 1'b1;
    tick;
    set_req(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 8'h00);
    clk__enable = 1'b0;
    repeat (2) tick;
    clk__enable = 1'b1;
    repeat (LAT - 2) tick;
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_frozen_pipe: valid=%b, required 0", resp_valid);
    end
    tick;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 8'h21 || resp_data !== 64'h0123_4567_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL en_resume_resp: valid=%b id=%h data=%h, required 1 21 01234567ffffffff",
               resp_valid, resp_id, resp_data);
    end
    tick;
    n_tests++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_single_pulse: valid=%b, required 0", resp_valid);
    end
  endtask

  task automatic test_reset_inflight;
    set_req(1'b1, 1'b1, 8'h41, 32'd3, 64'h0, 8'h00);
    tick;
    set_req(1'b1, 1'b1, 8'h42, 32'd3, 64'h0, 8'h00);
    tick;
    set_req(1'b1, 1'b1, 8'h43, 32'd3, 64'h0, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_reset: valid=%b init_done=%b ack=%b, required 0/0/0", resp_valid, init_done, ack);
    end
    repeat (2) tick;
    reset_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_tests++;
      if (ack !== 1'b0 || resp_valid !== 1'b0 || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reclear cycle %0d: ack=%b valid=%b init_done=%b, required 0/0/0",
                 c, ack, resp_valid, init_done);
      end
      tick;
    end
    n_tests++;
    if (ack !== 1'b1 || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reclear_done: ack=%b init_done=%b, required 1/1", ack, init_done);
    end
    tick;
    set_req(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 8'h00);
    repeat (LAT - 1) tick;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 8'h43 || resp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reclear_read: valid=%b id=%h data=%h, required 1 43 0", resp_valid, resp_id, resp_data);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_out_of_range();
    test_back_to_back();
    test_clk_enable();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
